// File: rtl/hsk_pkg.sv
// Shared types and default sizing for the processor byte-output responder (hsk_port).
package hsk_pkg;

    localparam int HSK_WIDTH = 8;
    localparam int HSK_DEPTH = 4;

    typedef enum logic [1:0] {
        HSK_IDLE  = 2'd0,
        HSK_STALL = 2'd1,
        HSK_ACK   = 2'd2
    } hsk_state_e;

endpackage

// File: rtl/hsk_port_if.sv
// Handshake and drain-port bundle; master = processor/device side, slave = hsk_port.
interface hsk_port_if import hsk_pkg::*; #(
    parameter int WIDTH = HSK_WIDTH,
    parameter int DEPTH = HSK_DEPTH
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] bus_out;
    logic             hsk_out;
    logic             hsk_in;
    logic             dev_rd;
    logic [WIDTH-1:0] dev_data;
    logic             dev_empty;
    logic             dev_full;
    logic [CW-1:0]    dev_count;

    modport master (
        output bus_out, hsk_out, dev_rd,
        input  hsk_in, dev_data, dev_empty, dev_full, dev_count
    );

    modport slave (
        input  bus_out, hsk_out, dev_rd,
        output hsk_in, dev_data, dev_empty, dev_full, dev_count
    );

endinterface

// File: rtl/hsk_fifo.sv
// Circular-buffer FIFO with first-word-fall-through read and a registered occupancy count.
module hsk_fifo import hsk_pkg::*; #(
    parameter int WIDTH = HSK_WIDTH,
    parameter int DEPTH = HSK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flags guard both sides so callers cannot overflow or underflow the buffer.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hsk_port.sv
// 4-phase responder for the processor byte output, buffering into hsk_fifo.
// Optional ack-timeout flag hsk_err when HSK_PORT_TIMEOUT_EN is defined.
module hsk_port import hsk_pkg::*; #(
    parameter int WIDTH = HSK_WIDTH,
    parameter int DEPTH = HSK_DEPTH
`ifdef HSK_PORT_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic     g_clk,
    input  logic     g_clr,
    hsk_port_if.slave bus
`ifdef HSK_PORT_TIMEOUT_EN
    ,
    output logic     hsk_err
`endif
);

    hsk_state_e state_q, state_d;
    logic       hsk_in_q;
    logic       push;
    logic       fifo_full;

    // A request is only accepted when the registered count says there is room;
    // a pop on the same edge frees space for the next edge, not this one.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            HSK_IDLE: begin
                if (bus.hsk_out) begin
                    if (!fifo_full) begin
                        push    = 1'b1;
                        state_d = HSK_ACK;
                    end else begin
                        state_d = HSK_STALL;
                    end
                end
            end
            HSK_STALL: begin
                if (!bus.hsk_out) begin
                    state_d = HSK_IDLE;
                end else if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = HSK_ACK;
                end
            end
            HSK_ACK: begin
                if (!bus.hsk_out) state_d = HSK_IDLE;
            end
            default: state_d = HSK_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q  <= HSK_IDLE;
            hsk_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hsk_in_q <= (state_d == HSK_ACK);
        end
    end

    assign bus.hsk_in = hsk_in_q;

    hsk_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (g_clk),
        .rst_n   (g_clr),
        .push_i  (push),
        .wdata_i (bus.bus_out),
        .pop_i   (bus.dev_rd),
        .rdata_o (bus.dev_data),
        .empty_o (bus.dev_empty),
        .full_o  (fifo_full),
        .count_o (bus.dev_count)
    );

    assign bus.dev_full = fifo_full;

`ifdef HSK_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    // Counter saturates at TIMEOUT so a very long ack cannot wrap and re-arm.
    always_comb begin
        tmo_d = '0;
        if (state_q == HSK_ACK)
            tmo_d = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
        err_d = err_q | (tmo_d == TW'(TIMEOUT));
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign hsk_err = err_q;
`endif

endmodule

// File: tb/tb_hsk_port.sv
// Bench for hsk_port: directed vector table, reset corner, randomized run vs queue model.
module tb_hsk_port;

    localparam int W = 8;
    localparam int D = 4;

    logic g_clk = 1'b0;
    logic g_clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 g_clk = ~g_clk;

    hsk_port_if #(.WIDTH(W), .DEPTH(D)) bus ();

`ifdef HSK_PORT_TIMEOUT_EN
    logic hsk_err;
    hsk_port #(.WIDTH(W), .DEPTH(D), .TIMEOUT(16)) dut (
        .g_clk (g_clk), .g_clr (g_clr), .bus (bus), .hsk_err (hsk_err));
`else
    hsk_port #(.WIDTH(W), .DEPTH(D)) dut (
        .g_clk (g_clk), .g_clr (g_clr), .bus (bus));
`endif

    // Reference: a byte queue plus "this request has been answered" flag.
    logic [W-1:0] mq[$];
    bit           served;

    typedef struct {
        logic         ho;
        logic [W-1:0] bo;
        logic         rd;
        logic         ein;
        int           ecnt;
        logic [W-1:0] ed;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_chk(input string tag);
        chk({tag, " hsk_in"}, int'(bus.hsk_in), int'(served));
        chk({tag, " count"}, int'(bus.dev_count), mq.size());
        chk({tag, " empty"}, int'(bus.dev_empty), int'(mq.size() == 0));
        chk({tag, " full"}, int'(bus.dev_full), int'(mq.size() == D));
        if (mq.size() > 0) chk({tag, " data"}, int'(bus.dev_data), int'(mq[0]));
    endtask

    // Drive inputs on the falling edge, clock once, advance the model, sample at +1.
    task automatic step(input logic ho, input logic [W-1:0] bo, input logic rd);
        int  sz;
        bit  pu, po;
        @(negedge g_clk);
        bus.hsk_out = ho;
        bus.bus_out = bo;
        bus.dev_rd  = rd;
        @(posedge g_clk);
        sz = mq.size();
        po = rd && (sz > 0);
        pu = ho && !served && (sz < D);
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back(bo);
        if (!ho) served = 1'b0;
        else if (pu) served = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge g_clk);
        bus.hsk_out = 1'b0;
        bus.dev_rd  = 1'b0;
        bus.bus_out = '0;
        g_clr = 1'b0;
        mq.delete();
        served = 1'b0;
        #1;
        chk("rst hsk_in", int'(bus.hsk_in), 0);
        chk("rst empty", int'(bus.dev_empty), 1);
        chk("rst full", int'(bus.dev_full), 0);
        chk("rst count", int'(bus.dev_count), 0);
        chk("rst data", int'(bus.dev_data), 0);
        @(negedge g_clk);
        g_clr = 1'b1;
    endtask

    task automatic addv(input logic ho, input logic [W-1:0] bo, input logic rd,
                        input logic ein, input int ecnt, input logic [W-1:0] ed);
        vec_t v;
        v.ho = ho; v.bo = bo; v.rd = rd; v.ein = ein; v.ecnt = ecnt; v.ed = ed;
        vt.push_back(v);
    endtask

    initial begin
        bus.hsk_out = 1'b0;
        bus.dev_rd  = 1'b0;
        bus.bus_out = '0;
        served = 1'b0;

        // single transfer, then pop and a read while empty
        addv(1, 8'hA5, 0, 1, 1, 8'hA5);
        addv(1, 8'hA5, 0, 1, 1, 8'hA5);
        addv(1, 8'hA5, 0, 1, 1, 8'hA5);
        addv(0, 8'h00, 0, 0, 1, 8'hA5);
        addv(0, 8'h00, 1, 0, 0, 8'h00);
        addv(0, 8'h00, 1, 0, 0, 8'h00);
        // fill to full
        addv(1, 8'h01, 0, 1, 1, 8'h01);
        addv(0, 8'h00, 0, 0, 1, 8'h01);
        addv(1, 8'h02, 0, 1, 2, 8'h01);
        addv(0, 8'h00, 0, 0, 2, 8'h01);
        addv(1, 8'h03, 0, 1, 3, 8'h01);
        addv(0, 8'h00, 0, 0, 3, 8'h01);
        addv(1, 8'h04, 0, 1, 4, 8'h01);
        addv(0, 8'h00, 0, 0, 4, 8'h01);
        // stall on full, pop releases it one edge later
        addv(1, 8'h05, 0, 0, 4, 8'h01);
        addv(1, 8'h05, 0, 0, 4, 8'h01);
        addv(1, 8'h05, 1, 0, 3, 8'h02);
        addv(1, 8'h05, 0, 1, 4, 8'h02);
        addv(0, 8'h00, 0, 0, 4, 8'h02);
        addv(0, 8'h00, 1, 0, 3, 8'h03);
        addv(0, 8'h00, 1, 0, 2, 8'h04);
        // push + pop at count 2 across pointer wrap
        addv(1, 8'h06, 1, 1, 2, 8'h05);
        addv(0, 8'h00, 0, 0, 2, 8'h05);
        addv(1, 8'h07, 1, 1, 2, 8'h06);
        addv(0, 8'h00, 1, 0, 1, 8'h07);
        addv(0, 8'h00, 1, 0, 0, 8'h00);
        // empty read ignored, next write lands correctly
        addv(0, 8'h00, 1, 0, 0, 8'h00);
        addv(1, 8'h3C, 0, 1, 1, 8'h3C);
        addv(0, 8'h00, 1, 0, 0, 8'h00);

        do_reset();

        for (int i = 0; i < vt.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vt[i].ho, vt[i].bo, vt[i].rd);
            chk({tag, " hsk_in"}, int'(bus.hsk_in), int'(vt[i].ein));
            chk({tag, " count"}, int'(bus.dev_count), vt[i].ecnt);
            chk({tag, " empty"}, int'(bus.dev_empty), int'(vt[i].ecnt == 0));
            chk({tag, " full"}, int'(bus.dev_full), int'(vt[i].ecnt == D));
            if (vt[i].ecnt > 0) chk({tag, " data"}, int'(bus.dev_data), int'(vt[i].ed));
            model_chk({tag, " mdl"});
        end

        // reset while acknowledging drops everything without a clock edge
        step(1, 8'h99, 0);
        chk("preRst hsk_in", int'(bus.hsk_in), 1);
        #2;
        g_clr = 1'b0;
        #1;
        chk("midAck hsk_in", int'(bus.hsk_in), 0);
        chk("midAck empty", int'(bus.dev_empty), 1);
        chk("midAck count", int'(bus.dev_count), 0);
        chk("midAck data", int'(bus.dev_data), 0);
        mq.delete();
        served = 1'b0;
        @(negedge g_clk);
        bus.hsk_out = 1'b0;
        g_clr = 1'b1;

        // randomized run: first biased to fill, then biased to drain
        for (int i = 0; i < 3000; i++) begin
            logic ho, rd;
            ho = ($urandom_range(0, 3) != 0);
            rd = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(ho, W'($urandom), rd);
            model_chk("rnd");
        end

`ifdef HSK_PORT_TIMEOUT_EN
        do_reset();
        chk("tmo rst", int'(hsk_err), 0);
        for (int k = 1; k <= 20; k++) begin
            step(1, 8'h55, 0);
            if (k == 16) chk("tmo before", int'(hsk_err), 0);
            if (k == 17) chk("tmo rise", int'(hsk_err), 1);
        end
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("tmo sticky", int'(hsk_err), 1);
        chk("tmo hsk_in", int'(bus.hsk_in), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsk_port.md
# hsk_port

Responder end of the processor's byte-output handshake. The processor drives `bus_out` and raises `hsk_out`; this block captures the byte into a small FIFO, answers on `hsk_in` using a 4-phase handshake, and exposes the buffered bytes to an external device through a first-word-fall-through drain port. It sits outside the processor, on the same `g_clk`, and is the device that the processor's `R_OUT` and handshake controller talk to.

## Interface
Parameters:
- `WIDTH`, 8: data width; matches `bus_out`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 16: cycles `hsk_in` may stay high before `hsk_err` is raised. Used only with `HSK_PORT_TIMEOUT_EN`.

Ports:
- `g_clk`, input, 1: the single clock, rising edge.
- `g_clr`, input, 1: asynchronous, active-low reset.
- `bus_out`, input, WIDTH: data from the processor. Valid while `hsk_out` is high.
- `hsk_out`, input, 1: request from the processor.
- `hsk_in`, output, 1: acknowledge to the processor. Registered.
- `dev_rd`, input, 1: device pops the head entry.
- `dev_data`, output, WIDTH: head entry (FWFT).
- `dev_empty`, output, 1: FIFO empty.
- `dev_full`, output, 1: FIFO full.
- `dev_count`, output, $clog2(DEPTH)+1: number of occupied entries.
- `hsk_err`, output, 1: timeout flag. Present only with `HSK_PORT_TIMEOUT_EN`.

## Operation
- State machine states:
  - IDLE: `hsk_in`=0.
  - STALL: request seen while the FIFO is full; `hsk_in`=0.
  - ACK: `hsk_in`=1.
- Transitions:
  - IDLE to ACK: `hsk_out`=1 and not full. `bus_out` is written at the tail on the same edge.
  - IDLE to STALL: `hsk_out`=1 and full.
  - STALL to ACK: full has cleared, using the registered count (after the pop takes effect). `bus_out` is written on that edge.
  - STALL to IDLE: `hsk_out` drops before space frees. Nothing is written.
  - ACK to IDLE: `hsk_out` sampled low.
  - ACK holds while `hsk_out`=1. A single request produces exactly one write, however long the request is held.
- After IDLE is re-entered, a new transfer needs `hsk_out` to be seen high again. Back-to-back 4-phase cycles are allowed.
- FIFO behaviour:
  - Circular buffer with wrapping read and write pointers, plus a count register.
  - Pop when `dev_rd`=1 and not empty. `dev_rd` while empty is ignored; no underflow.
  - Push and pop on the same edge leave the count unchanged.
  - A push never happens while full, so overflow is impossible.
- `dev_data` always shows `mem[rd_ptr]`. It is stale when empty.
- Reset values, all applied immediately and asynchronously when `g_clr` is low:
  - State IDLE.
  - `hsk_in`=0.
  - Pointers 0, count 0, so `dev_empty`=1 and `dev_full`=0.
  - Memory cleared to 0, so `dev_data`=0.
  - `hsk_err`=0.
- Reset during ACK drops `hsk_in` at once. The byte already written stays lost, because the FIFO is cleared.

## Timing
- Request sampled high at edge N (IDLE, not full): byte stored at edge N, `hsk_in` high after edge N. Latency is 1 cycle.
- `hsk_out` sampled low at edge M in ACK: `hsk_in` low after edge M.
- Minimum full transfer is 2 cycles per byte: request and ack overlap one cycle, then one release cycle.
- Pop at edge K: `dev_data` shows the next entry and `dev_count` decrements after edge K.
- Full FIFO, processor request pending, `dev_rd` at edge K: capture and ack happen at edge K+1.

## Configuration
- `HSK_PORT_TIMEOUT_EN` defined:
  - A counter increments every cycle in ACK and clears in any other state.
  - When the count reaches `TIMEOUT`, `hsk_err` is set and stays sticky until `g_clr`.
  - The state machine is unaffected.
- `HSK_PORT_TIMEOUT_EN` undefined: no counter, and the `hsk_err` port is absent.

## Structure
- Shared package `hsk_pkg`:
  - State enum: `HSK_IDLE`, `HSK_STALL`, `HSK_ACK`.
  - Default `WIDTH` and `DEPTH` constants.
- Sub-module `hsk_fifo` holds the circular buffer, pointers, count and flags. `hsk_port` holds the state machine and the optional timeout.

## Test plan
- Reset mid-ACK: assert `g_clr`=0 while `hsk_in`=1 → `hsk_in`=0, `dev_empty`=1, `dev_count`=0 immediately.
- Single transfer:
  - Stimulus: `bus_out`=8'hA5, `hsk_out` high for 3 cycles.
  - Required: exactly one entry, `dev_data`=8'hA5, `dev_count`=1, `hsk_in` high 1 cycle after the request and low 1 cycle after `hsk_out` falls.
- Fill to full:
  - Stimulus: write 8'h01, 8'h02, 8'h03, 8'h04, then request with 8'h05.
  - Required: `dev_full`=1, FSM in STALL, `hsk_in` stays 0.
  - Then pulse `dev_rd`: 8'h05 is captured on the following edge, and drain order reads 02, 03, 04, 05.
- Simultaneous push and pop at count 2: `dev_count` stays 2, and data order is preserved across pointer wrap.
- `dev_rd` while empty: count stays 0, pointers unchanged, and the next write reads back correctly.
- With `HSK_PORT_TIMEOUT_EN`, `TIMEOUT`=16: hold `hsk_out` high for 20 cycles → `hsk_err` rises at cycle 16 of ACK and stays 1 after release.
